// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared constants for the write-back stage: load-size codes,
//             halt FSM state encoding and the LUI placement shift.
//  Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

    // Load size field as delivered by decode; bit 1 set means full word.
    typedef logic [1:0] ld_size_t;

    localparam ld_size_t SZ_BYTE = 2'b00;
    localparam ld_size_t SZ_HALF = 2'b01;
    localparam ld_size_t SZ_WORD = 2'b11;

    // Halt FSM encoding.
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // LUI places the 16-bit immediate in the upper half of the word.
    localparam int LUI_SHIFT = 16;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_load_filter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_load_filter
//  Purpose  : Combinational load-data filter. Selects byte, halfword or full
//             word from a right-aligned load word and sign- or zero-extends
//             sub-word results.
//  Revision : 1.0  initial release
// ============================================================================
module wb_load_filter
    import wb_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] i_data,
    input  ld_size_t         i_size,
    input  logic             i_zero_extend,
    output logic [NBITS-1:0] o_data
);

    logic w_byte_fill;
    logic w_half_fill;

    assign w_byte_fill = ~i_zero_extend & i_data[7];
    assign w_half_fill = ~i_zero_extend & i_data[15];

    // Size select; any code with bit 1 set passes the whole word.
    always_comb begin
        o_data = i_data;
        case (i_size)
            SZ_BYTE: o_data = {{(NBITS-8){w_byte_fill}}, i_data[7:0]};
            SZ_HALF: o_data = {{(NBITS-16){w_half_fill}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule : wb_load_filter
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Write-back stage. Filters load data, selects the write-back
//             value (PC+8 / LUI / load / ALU), drives the register-file write
//             port, owns the sticky halt FSM and keeps cycle / retired
//             counters plus an optional last-write snapshot for debug.
//  Config   : WB_LAST_WRITE_EN - when defined, implements the last-write
//             snapshot registers; otherwise o_last_wr_* are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int RNBITS   = 5,
    parameter int CNT_BITS = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_step,
    input  logic [NBITS-1:0]    i_pc8,
    input  logic [NBITS-1:0]    i_instruction,
    input  logic [NBITS-1:0]    i_alu,
    input  logic [NBITS-1:0]    i_dato_memoria,
    input  logic [RNBITS-1:0]   i_registro_destino,
    input  logic [NBITS-1:0]    i_extension,
    input  logic                i_jal,
    input  logic                i_lui,
    input  logic                i_mem_to_reg,
    input  logic                i_reg_write,
    input  logic [1:0]          i_tamano_filtro_l,
    input  logic                i_zero_extend,
    input  logic                i_halt,
    output logic                o_wr_en,
    output logic [RNBITS-1:0]   o_wr_addr,
    output logic [NBITS-1:0]    o_wr_data,
    output logic                o_halted,
    output logic [CNT_BITS-1:0] o_cycle_cnt,
    output logic [CNT_BITS-1:0] o_retired_cnt,
    output logic [RNBITS-1:0]   o_last_wr_addr,
    output logic [NBITS-1:0]    o_last_wr_data
);

    logic [0:0]          r_state;
    logic [CNT_BITS-1:0] r_cycle_cnt;
    logic [CNT_BITS-1:0] r_retired_cnt;

    logic [NBITS-1:0]    w_load_data;
    logic [NBITS-1:0]    w_lui_value;
    logic [NBITS-1:0]    w_result;
    logic                w_advance;

    wb_load_filter #(
        .NBITS (NBITS)
    ) u_load_filter (
        .i_data        (i_dato_memoria),
        .i_size        (i_tamano_filtro_l),
        .i_zero_extend (i_zero_extend),
        .o_data        (w_load_data)
    );

    assign w_lui_value = i_extension << LUI_SHIFT;
    assign w_advance   = i_step & (r_state == ST_RUN);

    // Write-back value select: link, then LUI, then load, then ALU.
    always_comb begin
        w_result = i_alu;
        if (i_jal)
            w_result = i_pc8;
        else if (i_lui)
            w_result = w_lui_value;
        else if (i_mem_to_reg)
            w_result = w_load_data;
    end

    assign o_wr_en   = i_reg_write & w_advance & (i_registro_destino != '0);
    assign o_wr_addr = i_registro_destino;
    assign o_wr_data = w_result;
    assign o_halted  = (r_state == ST_HALTED);

    // Halt FSM: a stepped HALT parks the pipeline until reset.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_RUN;
        else if (w_advance && i_halt)
            r_state <= ST_HALTED;
    end

    // Cycle and retired counters advance only on stepped running cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_cnt   <= '0;
            r_retired_cnt <= '0;
        end else if (w_advance) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_BITS'(1);
            if (i_instruction != '0)
                r_retired_cnt <= r_retired_cnt + CNT_BITS'(1);
        end
    end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_retired_cnt = r_retired_cnt;

`ifdef WB_LAST_WRITE_EN
    logic [RNBITS-1:0] r_last_wr_addr;
    logic [NBITS-1:0]  r_last_wr_data;

    // Snapshot captures every committed register-file write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_wr_addr <= '0;
            r_last_wr_data <= '0;
        end else if (o_wr_en) begin
            r_last_wr_addr <= o_wr_addr;
            r_last_wr_data <= o_wr_data;
        end
    end

    assign o_last_wr_addr = r_last_wr_addr;
    assign o_last_wr_data = r_last_wr_data;
`else
    assign o_last_wr_addr = '0;
    assign o_last_wr_data = '0;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Scoreboard bench for wb_stage: directed scenarios followed by
//             randomized traffic, checked against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        step;
    logic [31:0] pc8, instr, alu, dmem, ext;
    logic [4:0]  rd;
    logic        jal, lui, m2r, rw, zext, halt;
    logic [1:0]  sz;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        halted;
    logic [31:0] cyc_cnt, ret_cnt;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    wb_stage #(
        .NBITS    (32),
        .RNBITS   (5),
        .CNT_BITS (32)
    ) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_step             (step),
        .i_pc8              (pc8),
        .i_instruction      (instr),
        .i_alu              (alu),
        .i_dato_memoria     (dmem),
        .i_registro_destino (rd),
        .i_extension        (ext),
        .i_jal              (jal),
        .i_lui              (lui),
        .i_mem_to_reg       (m2r),
        .i_reg_write        (rw),
        .i_tamano_filtro_l  (sz),
        .i_zero_extend      (zext),
        .i_halt             (halt),
        .o_wr_en            (wr_en),
        .o_wr_addr          (wr_addr),
        .o_wr_data          (wr_data),
        .o_halted           (halted),
        .o_cycle_cnt        (cyc_cnt),
        .o_retired_cnt      (ret_cnt),
        .o_last_wr_addr     (last_addr),
        .o_last_wr_data     (last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] ret;
        logic [4:0]  la;
        logic [31:0] ld;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model state
    bit          m_halted;
    int unsigned m_cyc, m_ret;
    logic [4:0]  m_la;
    logic [31:0] m_ld;

    function automatic logic [31:0] model_load(logic [31:0] d, logic [1:0] s, logic z);
        logic [31:0] v;
        if (s[1]) return d;
        if (s == 2'b01) begin
            v = d & 32'h0000_FFFF;
            if (!z && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = d & 32'h0000_00FF;
            if (!z && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_result();
        if (jal) return pc8;
        if (lui) return (ext & 32'h0000_FFFF) * 32'd65536;
        if (m2r) return model_load(dmem, sz, zext);
        return alu;
    endfunction

    function automatic bit model_wr_en();
        return rw && step && !m_halted && rd != 5'd0;
    endfunction

    // Push expectation for the current inputs, clock once, then advance model.
    task automatic issue(input string tag);
        exp_t e;
        bit   we;
        we        = model_wr_en();
        e.tag     = tag;
        e.wr_en   = we;
        e.wr_addr = rd;
        e.wr_data = model_result();
        e.halted  = m_halted;
        e.cyc     = m_cyc;
        e.ret     = m_ret;
        e.la      = m_la;
        e.ld      = m_ld;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            m_halted = 0; m_cyc = 0; m_ret = 0; m_la = 0; m_ld = 0;
        end else if (step && !m_halted) begin
            m_cyc = m_cyc + 1;
            if (instr != 0) m_ret = m_ret + 1;
`ifdef WB_LAST_WRITE_EN
            if (we) begin m_la = rd; m_ld = e.wr_data; end
`endif
            if (halt) m_halted = 1;
        end
    endtask

    task automatic idle();
        rst = 0; step = 0; pc8 = 0; instr = 0; alu = 0; dmem = 0; ext = 0;
        rd = 0; jal = 0; lui = 0; m2r = 0; rw = 0; sz = 0; zext = 0; halt = 0;
    endtask

    // Monitor: compare the DUT against the oldest expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (wr_en !== e.wr_en) begin n_fail++; $display("FAIL %s wr_en got %0b want %0b", e.tag, wr_en, e.wr_en); end
            if (wr_addr !== e.wr_addr) begin n_fail++; $display("FAIL %s wr_addr got %0d want %0d", e.tag, wr_addr, e.wr_addr); end
            if (wr_data !== e.wr_data) begin n_fail++; $display("FAIL %s wr_data got %h want %h", e.tag, wr_data, e.wr_data); end
            if (halted !== e.halted) begin n_fail++; $display("FAIL %s halted got %0b want %0b", e.tag, halted, e.halted); end
            if (cyc_cnt !== e.cyc) begin n_fail++; $display("FAIL %s cycle_cnt got %0d want %0d", e.tag, cyc_cnt, e.cyc); end
            if (ret_cnt !== e.ret) begin n_fail++; $display("FAIL %s retired_cnt got %0d want %0d", e.tag, ret_cnt, e.ret); end
            if (last_addr !== e.la) begin n_fail++; $display("FAIL %s last_wr_addr got %0d want %0d", e.tag, last_addr, e.la); end
            if (last_data !== e.ld) begin n_fail++; $display("FAIL %s last_wr_data got %h want %h", e.tag, last_data, e.ld); end
        end
    end

    initial begin
        idle();
        rst = 1;
        m_halted = 1; m_cyc = 0; m_ret = 0; m_la = 0; m_ld = 0;
        // First cycle: state unknown before reset, so just apply reset unchecked.
        @(posedge clk); #1;
        m_halted = 0;
        issue("reset_hold");
        idle();
        issue("reset_state");

        // Byte load, sign then zero extension
        step = 1; rw = 1; m2r = 1; rd = 5; dmem = 32'h0000_0080; instr = 32'h8000_0001;
        issue("byte_sext");
        zext = 1;
        issue("byte_zext");
        sz = 2'b01; zext = 0; dmem = 32'h1234_8001;
        issue("half_sext");
        sz = 2'b10;
        issue("word_10");

        // Priority
        idle(); step = 1; rw = 1; rd = 9; instr = 32'h1; jal = 1; lui = 1; pc8 = 32'h10; ext = 32'h1234;
        issue("prio_jal");
        jal = 0;
        issue("lui_only");

        // $0 guard and non-stepped cycle
        rd = 0;
        issue("zero_guard");
        rd = 3; step = 0;
        issue("no_step");
        issue("no_step_after");

        // Halt scenario from a fresh reset
        idle(); rst = 1; issue("reset2");
        idle(); step = 1; instr = 32'h11; alu = 32'h55; rw = 1; rd = 4; issue("h_i1");
        instr = 32'h0; rw = 0; issue("h_bubble");
        instr = 32'h22; rw = 1; rd = 6; alu = 32'h66; issue("h_i3");
        instr = 32'hFC00_0000; halt = 1; rw = 1; rd = 8; alu = 32'h88; issue("h_halt");
        halt = 0; instr = 32'h33; rd = 10; issue("halted_1");
        issue("halted_2");

        // Reset while halted, with step & halt in the same cycle
        rst = 1; halt = 1; rw = 0; issue("reset_halted");
        rst = 0; halt = 0; issue("after_reset");

        // Snapshot check
        idle(); step = 1; rw = 1; rd = 7; alu = 32'hDEAD_BEEF; instr = 32'h7; issue("snap_wr");
        rw = 0; alu = 32'h1; issue("snap_nowr");
        issue("snap_hold");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) < 3);
            step  = ($urandom_range(0, 3) != 0);
            pc8   = $urandom; alu = $urandom; dmem = $urandom; ext = $urandom;
            instr = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            rd    = 5'($urandom_range(0, 31));
            jal   = ($urandom_range(0, 7) == 0);
            lui   = ($urandom_range(0, 5) == 0);
            m2r   = $urandom_range(0, 1);
            rw    = rst ? 1'b0 : 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 3));
            zext  = $urandom_range(0, 1);
            halt  = ($urandom_range(0, 49) == 0);
            issue("random");
        end

        idle();
        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire
